// File: rtl/bilateral_pkg.sv
// Shared types and width helpers for the horizontal bilateral disparity filter.
//   state_e     : input-side FSM states (accept pixels / inject end-of-line bubbles)
//   tap_t       : one window entry; disp/conf fields are sized for the widest supported
//                 configuration and the filter uses only the low DISP_BITS/CONF_BITS bits
//   prod_width  : width of a conf*disp product
//   sum_width   : width of a sum of `taps` values of `base_bits` each
package bilateral_pkg;

  localparam int unsigned DispMaxBits = 16;
  localparam int unsigned ConfMaxBits = 16;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  typedef struct packed {
    logic                   valid;
    logic [DispMaxBits-1:0] disp;
    logic [ConfMaxBits-1:0] conf;
    logic [7:0]             gray;
    logic                   last_line;
    logic                   last_frame;
  } tap_t;

  function automatic int unsigned prod_width(input int unsigned disp_bits,
                                             input int unsigned conf_bits);
    return disp_bits + conf_bits;
  endfunction

  function automatic int unsigned sum_width(input int unsigned base_bits,
                                            input int unsigned taps);
    return base_bits + $clog2(taps);
  endfunction

endpackage

// File: rtl/bilateral_div.sv
// Unsigned divider with a registered quotient. A zero divisor yields a zero quotient.
//   clk, reset : clock, synchronous active-high reset (quotient cleared)
//   en         : quotient register load enable
//   num, den   : dividend and divisor
//   quo        : registered floor(num / den), or 0 when den == 0
module bilateral_div #(
  parameter int unsigned NumBits = 8,
  parameter int unsigned DenBits = 8,
  parameter int unsigned QuoBits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NumBits-1:0] num,
  input  logic [DenBits-1:0] den,
  output logic [QuoBits-1:0] quo
);

  logic [QuoBits-1:0] quo_d, quo_q;

  // Callers guarantee the true quotient fits QuoBits, so the narrowing cast is lossless.
  always_comb begin
    quo_d = '0;
    if (den != '0) begin
      quo_d = QuoBits'(num / NumBits'(den));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
    end else if (en) begin
      quo_q <= quo_d;
    end
  end

  assign quo = quo_q;

endmodule

// File: rtl/bilateral_filter_nx1.sv
// Horizontal (2*RADIUS+1)x1 confidence-weighted, gray-gated disparity filter.
//   clk, reset                 : clock, synchronous active-high reset
//   disparity_in/confidence_in : raw disparity and its confidence
//   gray_in                    : pixel grayscale
//   gray_threshold_in          : neighbour match threshold, taken with the first pixel of a line
//   first/last_pixel_in_line, last_pixel_in_frame : line/frame markers
//   in_valid/in_ready          : input handshake
//   disparity_out              : floor(sum(conf*disp) / sum(conf)) over kept taps
//   confidence_out             : floor(sum(conf) / kept taps)
//   gray_out, last_pixel_in_line_out, last_pixel_in_frame_out : centre pass-through
//   out_valid/out_ready        : output handshake
module bilateral_filter_nx1
  import bilateral_pkg::*;
#(
  parameter int unsigned DISP_BITS = 5,
  parameter int unsigned CONF_BITS = 8,
  parameter int unsigned RADIUS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DISP_BITS-1:0] disparity_in,
  input  logic [CONF_BITS-1:0] confidence_in,
  input  logic [7:0]           gray_in,
  input  logic [7:0]           gray_threshold_in,
  input  logic                 first_pixel_in_line,
  input  logic                 last_pixel_in_line,
  input  logic                 last_pixel_in_frame,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DISP_BITS-1:0] disparity_out,
  output logic [CONF_BITS-1:0] confidence_out,
  output logic [7:0]           gray_out,
  output logic                 last_pixel_in_line_out,
  output logic                 last_pixel_in_frame_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned Taps        = 2 * RADIUS + 1;
  localparam int unsigned ProdBits    = prod_width(DISP_BITS, CONF_BITS);
  localparam int unsigned ConfSumBits = sum_width(CONF_BITS, Taps);
  localparam int unsigned CdSumBits   = sum_width(ProdBits, Taps);
  localparam int unsigned KeepBits    = $clog2(Taps + 1);
  localparam int unsigned FlushBits   = $clog2(RADIUS + 1);

  logic                 en, in_fire, advance;
  state_e               state_q;
  logic [FlushBits-1:0] flush_cnt_q;
  logic [7:0]           thr_q;
  tap_t                 win_q [Taps];
  tap_t                 new_tap;
  logic                 fresh_q;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = !reset && en && (state_q == StRun);
  assign in_fire  = in_valid && in_ready;
  // The window moves only on real pixels or end-of-line bubbles, never on idle input.
  assign advance  = in_fire || (en && (state_q == StFlush));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
    end else if (en) begin
      unique case (state_q)
        StRun: begin
          if (in_fire && last_pixel_in_line) begin
            state_q     <= StFlush;
            flush_cnt_q <= FlushBits'(RADIUS);
          end
        end
        StFlush: begin
          flush_cnt_q <= flush_cnt_q - FlushBits'(1);
          if (flush_cnt_q == FlushBits'(1)) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q <= '0;
    end else if (in_fire && first_pixel_in_line) begin
      thr_q <= gray_threshold_in;
    end
  end

  always_comb begin
    new_tap = '0;
    if (in_fire) begin
      new_tap.valid      = 1'b1;
      new_tap.disp       = DispMaxBits'(disparity_in);
      new_tap.conf       = ConfMaxBits'(confidence_in);
      new_tap.gray       = gray_in;
      new_tap.last_line  = last_pixel_in_line;
      new_tap.last_frame = last_pixel_in_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Taps; i++) begin
        win_q[i] <= '0;
      end
    end else if (advance) begin
      win_q[0] <= new_tap;
      for (int i = 1; i < Taps; i++) begin
        win_q[i] <= win_q[i-1];
      end
    end
  end

  // Marks that the centre entry arrived with the last shift and has not been consumed yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      fresh_q <= 1'b0;
    end else if (en) begin
      fresh_q <= advance;
    end
  end

  // Stage A: gray gating and per-tap weighting.
  logic [7:0]           lo, hi;
  logic [8:0]           hi_sum;
  logic [ProdBits-1:0]  prod_d [Taps];
  logic [CONF_BITS-1:0] conf_d [Taps];
  logic [KeepBits-1:0]  keep_cnt_d;

  always_comb begin
    lo     = (win_q[RADIUS].gray > thr_q) ? win_q[RADIUS].gray - thr_q : 8'd0;
    hi_sum = {1'b0, win_q[RADIUS].gray} + {1'b0, thr_q};
    hi     = hi_sum[8] ? 8'hff : hi_sum[7:0];
    keep_cnt_d = '0;
    for (int i = 0; i < Taps; i++) begin
      prod_d[i] = '0;
      conf_d[i] = '0;
      if (i == RADIUS ||
          (win_q[i].valid && win_q[i].gray >= lo && win_q[i].gray <= hi)) begin
        prod_d[i]  = ProdBits'(win_q[i].conf[CONF_BITS-1:0]) *
                     ProdBits'(win_q[i].disp[DISP_BITS-1:0]);
        conf_d[i]  = win_q[i].conf[CONF_BITS-1:0];
        keep_cnt_d = keep_cnt_d + KeepBits'(1);
      end
    end
  end

  logic                 a_valid_q, a_ll_q, a_lf_q;
  logic [ProdBits-1:0]  a_prod_q [Taps];
  logic [CONF_BITS-1:0] a_conf_q [Taps];
  logic [KeepBits-1:0]  a_keep_q;
  logic [7:0]           a_gray_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_keep_q  <= '0;
      a_gray_q  <= '0;
      a_ll_q    <= 1'b0;
      a_lf_q    <= 1'b0;
      for (int i = 0; i < Taps; i++) begin
        a_prod_q[i] <= '0;
        a_conf_q[i] <= '0;
      end
    end else if (en) begin
      a_valid_q <= fresh_q && win_q[RADIUS].valid;
      a_keep_q  <= keep_cnt_d;
      a_gray_q  <= win_q[RADIUS].gray;
      a_ll_q    <= win_q[RADIUS].last_line;
      a_lf_q    <= win_q[RADIUS].last_frame;
      for (int i = 0; i < Taps; i++) begin
        a_prod_q[i] <= prod_d[i];
        a_conf_q[i] <= conf_d[i];
      end
    end
  end

  // Stage B: sums across the window.
  logic [ConfSumBits-1:0] conf_sum_d, b_conf_sum_q;
  logic [CdSumBits-1:0]   cd_sum_d, b_cd_sum_q;
  logic [KeepBits-1:0]    b_keep_q;
  logic [7:0]             b_gray_q;
  logic                   b_valid_q, b_ll_q, b_lf_q;

  always_comb begin
    conf_sum_d = '0;
    cd_sum_d   = '0;
    for (int i = 0; i < Taps; i++) begin
      conf_sum_d = conf_sum_d + ConfSumBits'(a_conf_q[i]);
      cd_sum_d   = cd_sum_d + CdSumBits'(a_prod_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid_q    <= 1'b0;
      b_conf_sum_q <= '0;
      b_cd_sum_q   <= '0;
      b_keep_q     <= '0;
      b_gray_q     <= '0;
      b_ll_q       <= 1'b0;
      b_lf_q       <= 1'b0;
    end else if (en) begin
      b_valid_q    <= a_valid_q;
      b_conf_sum_q <= conf_sum_d;
      b_cd_sum_q   <= cd_sum_d;
      b_keep_q     <= a_keep_q;
      b_gray_q     <= a_gray_q;
      b_ll_q       <= a_ll_q;
      b_lf_q       <= a_lf_q;
    end
  end

  // Stage C: division and registered outputs.
  bilateral_div #(
    .NumBits(CdSumBits),
    .DenBits(ConfSumBits),
    .QuoBits(DISP_BITS)
  ) u_div_disp (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .num  (b_cd_sum_q),
    .den  (b_conf_sum_q),
    .quo  (disparity_out)
  );

  bilateral_div #(
    .NumBits(ConfSumBits),
    .DenBits(KeepBits),
    .QuoBits(CONF_BITS)
  ) u_div_conf (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .num  (b_conf_sum_q),
    .den  (b_keep_q),
    .quo  (confidence_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid               <= 1'b0;
      gray_out                <= '0;
      last_pixel_in_line_out  <= 1'b0;
      last_pixel_in_frame_out <= 1'b0;
    end else if (en) begin
      out_valid               <= b_valid_q;
      gray_out                <= b_gray_q;
      last_pixel_in_line_out  <= b_ll_q;
      last_pixel_in_frame_out <= b_lf_q;
    end
  end

endmodule

// File: tb/tb_bilateral_filter_nx1.sv
// Bench for bilateral_filter_nx1: two instances (RADIUS 1 and 2) see the same accepted beats
// and are each checked against a per-line reference model of the filter equations.
module tb_bilateral_filter_nx1;

  localparam int MaxLen = 32;

  typedef struct packed {
    logic [4:0] disp;
    logic [7:0] conf;
    logic [7:0] gray;
    logic       ll;
    logic       lf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] drv_disp;
  logic [7:0] drv_conf, drv_gray, drv_thr;
  logic       drv_first, drv_last, drv_lframe, drv_valid;
  logic       in_valid_g;
  logic       in_ready  [2];
  logic       out_ready [2];
  logic       out_valid [2];
  logic [4:0] o_disp    [2];
  logic [7:0] o_conf    [2];
  logic [7:0] o_gray    [2];
  logic       o_ll      [2];
  logic       o_lf      [2];

  // Offer a beat only when both instances can take it, so both see identical lines.
  assign in_valid_g = drv_valid && in_ready[0] && in_ready[1];

  bilateral_filter_nx1 #(.DISP_BITS(5), .CONF_BITS(8), .RADIUS(1)) u_dut_r1 (
    .clk                    (clk),
    .reset                  (reset),
    .disparity_in           (drv_disp),
    .confidence_in          (drv_conf),
    .gray_in                (drv_gray),
    .gray_threshold_in      (drv_thr),
    .first_pixel_in_line    (drv_first),
    .last_pixel_in_line     (drv_last),
    .last_pixel_in_frame    (drv_lframe),
    .in_valid               (in_valid_g),
    .in_ready               (in_ready[0]),
    .disparity_out          (o_disp[0]),
    .confidence_out         (o_conf[0]),
    .gray_out               (o_gray[0]),
    .last_pixel_in_line_out (o_ll[0]),
    .last_pixel_in_frame_out(o_lf[0]),
    .out_valid              (out_valid[0]),
    .out_ready              (out_ready[0])
  );

  bilateral_filter_nx1 #(.DISP_BITS(5), .CONF_BITS(8), .RADIUS(2)) u_dut_r2 (
    .clk                    (clk),
    .reset                  (reset),
    .disparity_in           (drv_disp),
    .confidence_in          (drv_conf),
    .gray_in                (drv_gray),
    .gray_threshold_in      (drv_thr),
    .first_pixel_in_line    (drv_first),
    .last_pixel_in_line     (drv_last),
    .last_pixel_in_frame    (drv_lframe),
    .in_valid               (in_valid_g),
    .in_ready               (in_ready[1]),
    .disparity_out          (o_disp[1]),
    .confidence_out         (o_conf[1]),
    .gray_out               (o_gray[1]),
    .last_pixel_in_line_out (o_ll[1]),
    .last_pixel_in_frame_out(o_lf[1]),
    .out_valid              (out_valid[1]),
    .out_ready              (out_ready[1])
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_exp [2];
  int   n_out [2];
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [7:0] ln_gray [MaxLen];
  logic [4:0] ln_disp [MaxLen];
  logic [7:0] ln_conf [MaxLen];
  bit   mon_en      = 1'b0;
  bit   rand_stall  = 1'b0;
  bit   force_stall = 1'b0;
  int   gap_max     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: neighbours within r positions of j on the same line, kept if the centre or
  // within thr gray levels of the centre; conf-weighted mean disparity, mean confidence.
  function automatic exp_t model_px(input int r, input int len, input int j, input int thr,
                                    input bit fe);
    exp_t e;
    int cd, cs, n, dg;
    cd = 0;
    cs = 0;
    n  = 0;
    for (int k = j - r; k <= j + r; k++) begin
      if (k < 0 || k >= len) continue;
      dg = int'(ln_gray[k]) - int'(ln_gray[j]);
      if (dg < 0) dg = -dg;
      if (k == j || dg <= thr) begin
        cd += int'(ln_conf[k]) * int'(ln_disp[k]);
        cs += int'(ln_conf[k]);
        n++;
      end
    end
    e.disp = (cs == 0) ? 5'd0 : 5'(cd / cs);
    e.conf = 8'(cs / n);
    e.gray = ln_gray[j];
    e.ll   = (j == len - 1);
    e.lf   = fe && (j == len - 1);
    return e;
  endfunction

  task automatic drive_beat(input int j, input int len, input int thr, input bit fe);
    int guard;
    guard      = 0;
    drv_disp   = ln_disp[j];
    drv_conf   = ln_conf[j];
    drv_gray   = ln_gray[j];
    drv_first  = (j == 0);
    drv_last   = (j == len - 1);
    drv_lframe = fe && (j == len - 1);
    // Only the first beat's threshold should matter; the others carry noise.
    drv_thr    = (j == 0) ? 8'(thr) : 8'($urandom_range(0, 255));
    drv_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[0] && in_ready[1]) break;
      guard++;
      if (guard > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic send_line(input int len, input int thr, input bit fe, input bit chk_flush);
    int g;
    for (int j = 0; j < len; j++) begin
      exp_q0.push_back(model_px(1, len, j, thr, fe));
      exp_q1.push_back(model_px(2, len, j, thr, fe));
      n_exp[0]++;
      n_exp[1]++;
    end
    for (int j = 0; j < len; j++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      drive_beat(j, len, thr, fe);
    end
    if (chk_flush) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("flush_ready_r1", in_ready[0], (c < 1) ? 0 : 1);
        check("flush_ready_r2", in_ready[1], (c < 2) ? 0 : 1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_random(input int len, input bit zero_conf);
    int base;
    base = $urandom_range(40, 200);
    for (int j = 0; j < len; j++) begin
      ln_gray[j] = 8'(base + $urandom_range(0, 40));
      ln_disp[j] = 5'($urandom_range(0, 31));
      ln_conf[j] = zero_conf ? 8'd0 : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    drv_valid = 1'b0;
    @(negedge clk);
    check("reset_in_ready_r1", in_ready[0], 0);
    check("reset_in_ready_r2", in_ready[1], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_out_valid_r%0d", k + 1), out_valid[k], 0);
      check($sformatf("rst_disp_r%0d", k + 1), o_disp[k], 0);
      check($sformatf("rst_conf_r%0d", k + 1), o_conf[k], 0);
      check($sformatf("rst_gray_r%0d", k + 1), o_gray[k], 0);
      check($sformatf("rst_markers_r%0d", k + 1), {o_ll[k], o_lf[k]}, 0);
      check($sformatf("post_rst_ready_r%0d", k + 1), in_ready[k], 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_left_r1", exp_q0.size(), 0);
    check("drain_left_r2", exp_q1.size(), 0);
  endtask

  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (force_stall) out_ready[k] = 1'b0;
        else if (rand_stall) out_ready[k] = ($urandom_range(0, 3) != 0);
        else out_ready[k] = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard on transfers, hold check across stalled cycles.
  initial begin
    exp_t e;
    exp_t prev [2];
    bit   prev_stall [2];
    bit   have;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        continue;
      end
      for (int k = 0; k < 2; k++) begin
        if (prev_stall[k]) begin
          check($sformatf("hold_valid_r%0d", k + 1), out_valid[k], 1);
          check($sformatf("hold_disp_r%0d", k + 1), o_disp[k], prev[k].disp);
          check($sformatf("hold_conf_r%0d", k + 1), o_conf[k], prev[k].conf);
          check($sformatf("hold_gray_r%0d", k + 1), o_gray[k], prev[k].gray);
          check($sformatf("hold_markers_r%0d", k + 1), {o_ll[k], o_lf[k]},
                {prev[k].ll, prev[k].lf});
        end
        if (out_valid[k] && !out_ready[k]) begin
          check($sformatf("stall_in_ready_r%0d", k + 1), in_ready[k], 0);
          prev_stall[k] = 1'b1;
          prev[k].disp  = o_disp[k];
          prev[k].conf  = o_conf[k];
          prev[k].gray  = o_gray[k];
          prev[k].ll    = o_ll[k];
          prev[k].lf    = o_lf[k];
        end else begin
          prev_stall[k] = 1'b0;
        end
        if (out_valid[k] && out_ready[k]) begin
          n_out[k]++;
          have = (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
          if (!have) begin
            check($sformatf("unexpected_out_r%0d", k + 1), 1, 0);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("disp_r%0d", k + 1), o_disp[k], e.disp);
            check($sformatf("conf_r%0d", k + 1), o_conf[k], e.conf);
            check($sformatf("gray_r%0d", k + 1), o_gray[k], e.gray);
            check($sformatf("last_line_r%0d", k + 1), o_ll[k], e.ll);
            check($sformatf("last_frame_r%0d", k + 1), o_lf[k], e.lf);
          end
        end
      end
    end
  end

  initial begin
    n_exp[0] = 0;
    n_exp[1] = 0;
    n_out[0] = 0;
    n_out[1] = 0;
    reset      = 1'b1;
    drv_valid  = 1'b0;
    drv_disp   = '0;
    drv_conf   = '0;
    drv_gray   = '0;
    drv_thr    = '0;
    drv_first  = 1'b0;
    drv_last   = 1'b0;
    drv_lframe = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Uniform line: every output equals the input, ready drops for RADIUS cycles after it.
    for (int j = 0; j < 5; j++) begin
      ln_gray[j] = 8'd100;
      ln_conf[j] = 8'd10;
      ln_disp[j] = 5'd4;
    end
    send_line(5, 20, 1'b0, 1'b1);

    // Gray edge: the 120 pixel is excluded from its neighbours' windows.
    ln_gray[0] = 8'd100; ln_gray[1] = 8'd100; ln_gray[2] = 8'd120;
    ln_disp[0] = 5'd2;   ln_disp[1] = 5'd2;   ln_disp[2] = 5'd9;
    for (int j = 0; j < 3; j++) ln_conf[j] = 8'd10;
    send_line(3, 5, 1'b0, 1'b1);

    // All-zero confidence.
    fill_random(6, 1'b1);
    send_line(6, 30, 1'b0, 1'b0);

    // Single-pixel line.
    ln_gray[0] = 8'd55;
    ln_disp[0] = 5'd7;
    ln_conf[0] = 8'd20;
    send_line(1, 10, 1'b1, 1'b1);
    wait_drain();

    // Four-cycle output stall in the middle of a streaming line.
    fill_random(10, 1'b0);
    fork
      send_line(10, 25, 1'b0, 1'b0);
      begin
        repeat (7) @(posedge clk);
        #1;
        force_stall = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        force_stall = 1'b0;
      end
    join
    wait_drain();

    // Reset with two pixels of a line in flight; nothing from it may appear.
    fill_random(5, 1'b0);
    drive_beat(0, 5, 20, 1'b0);
    drive_beat(1, 5, 20, 1'b0);
    do_reset();
    fill_random(3, 1'b0);
    send_line(3, 15, 1'b1, 1'b0);
    wait_drain();

    // Random lines with input gaps and random output backpressure.
    rand_stall = 1'b1;
    gap_max    = 2;
    for (int l = 0; l < 25; l++) begin
      int len;
      len = $urandom_range(1, 12);
      fill_random(len, ($urandom_range(0, 7) == 0));
      send_line(len, $urandom_range(0, 40), ($urandom_range(0, 3) == 0), 1'b0);
    end
    wait_drain();
    rand_stall = 1'b0;

    check("count_r1", n_out[0], n_exp[0]);
    check("count_r2", n_out[1], n_exp[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
